// File: rtl/rf_pkg.sv
// Types and constants shared by the register file and its write-back queue.
package rf_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Write request, register-file write port, and forwarding lookup of the write-back queue.
interface wb_queue_if #(
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int DEPTH      = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  drain_en;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic                  lk_hit;
  logic [DATA_WIDTH-1:0] lk_data;
  logic [CNT_W-1:0]      count;
  logic                  empty;

  modport master (
    output in_valid, in_addr, in_data, drain_en, lk_addr,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, lk_hit, lk_data, count, empty
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, lk_addr,
    output in_ready, rf_wen, rf_waddr, rf_wdata, lk_hit, lk_data, count, empty
  );

endinterface

// File: rtl/wbq_match.sv
// Youngest-first lookup of a register index across the pending write-back entries.
module wbq_match
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wbq_entry_t                   i_entries [DEPTH],
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_ptr,
  input  logic [rf_pkg::ADDR_WIDTH-1:0] i_lk_addr,
  output logic                         o_hit,
  output logic [rf_pkg::DATA_WIDTH-1:0] o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest slot to youngest so the last match written is the youngest one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_idx = i_wr_ptr - PTR_W'(k);
      if ((i_lk_addr != ZERO_REG) && i_valid[w_idx] &&
          (i_entries[w_idx].addr == i_lk_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue feeding the single register-file write port, with forwarding of
// still-pending writes to readers.
module wb_queue
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input logic       clk,
  input logic       rst_n,
  wb_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wbq_entry_t       r_entries [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0]      w_valid;
  logic                  w_empty;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_enq;
  logic                  w_deq;
  wbq_entry_t            w_head;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_lk_hit;
  logic [DATA_WIDTH-1:0] w_lk_data;

  assign w_empty  = (r_count == '0);
  assign w_ready  = (r_count < FULL_CNT) && rst_n;
  assign w_accept = bus.in_valid && w_ready;
  // Writes to x0 complete the handshake but are dropped.
  assign w_enq    = w_accept && (bus.in_addr != ZERO_REG);
  assign w_deq    = !w_empty && bus.drain_en && rst_n;

  assign w_head      = r_entries[r_rd_ptr];
  assign w_head_addr = w_empty ? '0 : w_head.addr;
  assign w_head_data = w_empty ? '0 : w_head.data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    logic [PTR_W-1:0] w_off;
    assign w_off      = PTR_W'(g) - r_rd_ptr;
    assign w_valid[g] = {1'b0, w_off} < r_count;
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_entries[r_wr_ptr] <= '{addr: bus.in_addr, data: bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  wbq_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .i_entries (r_entries),
    .i_valid   (w_valid),
    .i_wr_ptr  (r_wr_ptr),
    .i_lk_addr (bus.lk_addr),
    .o_hit     (w_lk_hit),
    .o_data    (w_lk_data)
  );

  assign bus.in_ready = w_ready;
  assign bus.rf_wen   = w_deq;
  assign bus.rf_waddr = w_head_addr;
  assign bus.rf_wdata = w_head_data;
  assign bus.lk_hit   = w_lk_hit;
  assign bus.lk_data  = w_lk_data;
  assign bus.count    = r_count;
  assign bus.empty    = w_empty;

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue that is the writer side of the core's single-write-port register file. It accepts register write requests from the execute/load paths through a valid/ready handshake and buffers up to DEPTH of them. It drains one per cycle onto the register file's `wen/waddr/wdata` port and forwards still-pending data to readers so that no stale register value is observed.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, register index width (matches register file).
- `DATA_WIDTH`, 32, register data width.
- `DEPTH`, 4, queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  write request present.
- `in_ready`  out  1  queue can accept; `in_ready = (count < DEPTH) && rst_n`.
- `in_addr`  in  ADDR_WIDTH  destination register index.
- `in_data`  in  DATA_WIDTH  value to write.
- `drain_en`  in  1  permits popping the head this cycle.
- `rf_wen`  out  1  register file write enable.
- `rf_waddr`  out  ADDR_WIDTH  head entry index.
- `rf_wdata`  out  DATA_WIDTH  head entry data.
- `lk_addr`  in  ADDR_WIDTH  read-port index to check for pending writes.
- `lk_hit`  out  1  a pending entry targets `lk_addr`.
- `lk_data`  out  DATA_WIDTH  data of the youngest matching entry; 0 when `!lk_hit`.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.
- `empty`  out  1  `count == 0`.

## Operation
- Circular buffer with `wr_ptr`, `rd_ptr` (log2 DEPTH bits, natural wrap) and `count`; per-entry `addr`, `data`.
- Enqueue: `in_valid && in_ready` at posedge → entry written at `wr_ptr`, `wr_ptr++`.
- Index 0: a request with `in_addr == 0` is accepted (handshake completes), but nothing is stored and no pointer or count changes.
- Dequeue: `rf_wen = !empty && drain_en` (combinational). `rf_waddr`/`rf_wdata` always show the head; both read 0 when empty. At posedge with `rf_wen`, `rd_ptr++`.
- Count update: enq and deq in the same cycle → count unchanged. Enq only → +1. Deq only → −1.
- Full: `in_ready` is low even if a dequeue happens that cycle; there is no pass-through credit.
- Empty: an enqueue is stored, and `rf_wen` stays 0 that cycle. There is no bypass from input straight to the RF port.
- Lookup: compares `lk_addr` against all stored entries. The youngest match, counted from `wr_ptr-1` back toward `rd_ptr`, wins.
  - `lk_addr == 0` → `lk_hit = 0`.
  - The head entry being popped this cycle still counts as a hit.
- Ordering: RF writes occur in acceptance order, so the final RF value for duplicate indices is the youngest value.

## Timing
- Reset (`rst_n` low at posedge): `count = 0`, `wr_ptr = rd_ptr = 0`; entry contents are don't-care.
- Output values while `rst_n` is low:
  - `in_ready = 0`, `rf_wen = 0`, `lk_hit = 0`, `empty = 1` once the reset edge has occurred.
  - Requests presented while `rst_n` is low are never accepted.
- Reset mid-drain: pending entries are discarded and never written.
- Latency: a request accepted at edge N drives `rf_wen` in cycle N+1 (if first in line and `drain_en`), and the RF is updated at edge N+1.
- Lookup: the entry becomes visible on `lk_hit` in cycle N+1. It is no longer visible in the cycle after its RF write edge, when the RF itself holds the value.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained.
- Combinational paths:
  - `lk_addr` → `lk_hit`/`lk_data`.
  - `drain_en` → `rf_wen`.
  - No path from `in_*` to any output.

## Structure
- Shared package `rf_pkg`: `ADDR_WIDTH`/`DATA_WIDTH` defaults, typedef `wbq_entry_t {addr, data}`, constant `ZERO_REG = 0`. The register file and this block both import it.
- One sub-module, `wbq_match`: DEPTH-way youngest-first priority compare. Inputs are the entry array, valid mask, `wr_ptr` and `lk_addr`; outputs are hit and data.
- The top level holds pointers, count, storage and handshake logic.

## Test plan
- Reset and single write: after reset, `in_ready = 1`, `empty = 1`. Enqueue (addr 5, 0xDEADBEEF) with `drain_en = 1` → next cycle `rf_wen = 1`, `rf_waddr = 5`, `rf_wdata = 0xDEADBEEF`; the cycle after, `empty = 1`.
- Fill and back-pressure: `drain_en = 0`, enqueue 4 writes (addrs 1–4) → `count = 4`, `in_ready = 0`. A 5th request is held and not accepted. Raise `drain_en` → RF writes 1, 2, 3, 4 on consecutive cycles, and the 5th is accepted once `count = 3`.
- x0 discard: enqueue (0, 0x1234) → `in_ready` handshake completes, `count` stays 0, `rf_wen` never asserts, and `lk_addr = 0` gives `lk_hit = 0`.
- Forwarding priority: `drain_en = 0`, enqueue (7, 0xA) then (7, 0xB) → `lk_addr = 7` gives `lk_hit = 1`, `lk_data = 0xB`. Drain one → still 0xB. Drain both → `lk_hit = 0`.
- Simultaneous enqueue/dequeue across wrap: with `drain_en = 1`, stream 10 back-to-back writes (addrs 1–10) → `count` holds at 1, the RF sees addrs 1–10 in order, and pointers wrap twice with no loss.
- Reset mid-operation: 3 entries pending, assert `rst_n = 0` for 1 cycle → no further `rf_wen`, `count = 0`, `lk_hit = 0` for the previous addrs.
